// File: rtl/chad_intc.sv
// Vectored interrupt controller: synchronised sources, per-channel edge/level
// pending logic and a fixed-priority IDLE/REQ/ACK handshake with the core.
module chad_intc #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 18,
  parameter int VBASE    = 1
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic [CHANNELS-1:0] src,
  input  logic                io_wr,
  input  logic                io_rd,
  input  logic [1:0]          io_addr,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic                irq,
  output logic [3:0]          ivec,
  input  logic                iack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_e;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_MODE    = 2'd2;
  localparam logic [1:0] A_SWTRIG  = 2'd3;

  logic [CHANNELS-1:0] sync1_q, sync2_q, prev_q;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [CHANNELS-1:0] mode_q, mode_d;
  state_e              state_q, state_d;
  logic [3:0]          chan_q, chan_d;
  logic [3:0]          ivec_q, ivec_d;

  logic [CHANNELS-1:0] wr_data, active, sel_mask, set_ev, clr_ev, edge_next, mode_chg;
  logic [3:0]          win;
  logic                unused_din;

  assign wr_data    = din[CHANNELS-1:0];
  assign unused_din = ^din;
  assign active     = pending_q & enable_q;
  assign sel_mask   = CHANNELS'(1) << chan_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    set_ev   = sync2_q & ~prev_q;
    clr_ev   = '0;
    if (io_wr && io_addr == A_ENABLE)  enable_d = wr_data;
    if (io_wr && io_addr == A_MODE)    mode_d   = wr_data;
    if (io_wr && io_addr == A_SWTRIG)  set_ev   = set_ev | wr_data;
    if (io_wr && io_addr == A_PENDING) clr_ev   = wr_data;
    if (state_q == S_REQ && iack)      clr_ev   = clr_ev | sel_mask;
    mode_chg  = mode_d ^ mode_q;
    // Set wins over clear; level channels simply track the synchronised source.
    edge_next = set_ev | (pending_q & ~clr_ev);
    pending_d = ((mode_q & edge_next) | (~mode_q & sync2_q)) & ~mode_chg;
  end

  always_comb begin
    win = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (active[k]) win = 4'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    ivec_d  = ivec_q;
    unique case (state_q)
      S_IDLE: begin
        if (|active) begin
          chan_d  = win;
          ivec_d  = 4'(VBASE) + win;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (iack)                          state_d = S_ACK;
        else if ((active & sel_mask) == '0) state_d = S_IDLE;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      state_q   <= S_IDLE;
      chan_q    <= '0;
      ivec_q    <= '0;
    end else begin
      sync1_q   <= src;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      chan_q    <= chan_d;
      ivec_q    <= ivec_d;
    end
  end

  assign irq  = (state_q == S_REQ);
  assign ivec = ivec_q;

  always_comb begin
    dout = '0;
    if (io_rd) begin
      unique case (io_addr)
        A_ENABLE:  dout = WIDTH'(enable_q);
        A_PENDING: dout = WIDTH'(pending_q);
        A_MODE:    dout = WIDTH'(mode_q);
        default:   dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_chad_intc.sv
// Bench for chad_intc: directed scenarios with fixed expectations plus a
// randomized run compared each cycle against a behavioural model.
module tb_chad_intc;
  localparam int N  = 8;
  localparam int W  = 18;
  localparam int VB = 1;

  logic         clk = 0, resetq = 0;
  logic [N-1:0] src = '0;
  logic         io_wr = 0, io_rd = 0, iack = 0;
  logic [1:0]   io_addr = '0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         irq;
  logic [3:0]   ivec;

  int n_tests = 0;
  int n_fail  = 0;

  chad_intc #(.CHANNELS(N), .WIDTH(W), .VBASE(VB)) dut (
    .clk(clk), .resetq(resetq), .src(src), .io_wr(io_wr), .io_rd(io_rd),
    .io_addr(io_addr), .din(din), .dout(dout), .irq(irq), .ivec(ivec), .iack(iack)
  );

  always #5 clk = ~clk;

  // Behavioural model: registers as bit vectors, handshake as busy/gap flags.
  logic [N-1:0] m_s1, m_s2, m_prev, m_pend, m_en, m_mode;
  bit           m_busy, m_gap;
  int           m_chan;

  function automatic int lowest(input logic [N-1:0] a);
    for (int k = 0; k < N; k++) if (a[k]) return k;
    return 0;
  endfunction

  always @(posedge clk or negedge resetq) begin : model
    logic [N-1:0] a, chg, np, nen, nmode;
    bit setb, clrb;
    if (!resetq) begin
      m_s1 <= '0; m_s2 <= '0; m_prev <= '0; m_pend <= '0; m_en <= '0; m_mode <= '0;
      m_busy <= 0; m_gap <= 0; m_chan <= 0;
    end else begin
      nen   = (io_wr && io_addr == 2'd0) ? din[N-1:0] : m_en;
      nmode = (io_wr && io_addr == 2'd2) ? din[N-1:0] : m_mode;
      chg   = nmode ^ m_mode;
      for (int k = 0; k < N; k++) begin
        if (chg[k]) np[k] = 1'b0;
        else if (!m_mode[k]) np[k] = m_s2[k];
        else begin
          setb  = (m_s2[k] && !m_prev[k]) || (io_wr && io_addr == 2'd3 && din[k]);
          clrb  = (io_wr && io_addr == 2'd1 && din[k]) || (m_busy && iack && m_chan == k);
          np[k] = setb || (m_pend[k] && !clrb);
        end
      end
      a = m_pend & m_en;
      if (m_busy) begin
        if (iack) begin m_busy <= 0; m_gap <= 1; end
        else if (!a[m_chan]) m_busy <= 0;
      end else if (m_gap) m_gap <= 0;
      else if (a != '0) begin
        m_chan <= lowest(a);
        m_busy <= 1;
      end
      m_s1 <= src; m_s2 <= m_s1; m_prev <= m_s2;
      m_pend <= np; m_en <= nen; m_mode <= nmode;
    end
  end

  // Helpers are called at a falling edge and return at a falling edge.
  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    io_wr = 1; io_addr = a; din = d;
    @(negedge clk);
    io_wr = 0; din = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [W-1:0] v);
    io_addr = a; io_rd = 1;
    #1 v = dout;
    io_rd = 0;
  endtask

  task automatic pulse_iack();
    iack = 1;
    @(negedge clk);
    iack = 0;
  endtask

  task automatic pulse_src(input int ch);
    src[ch] = 1'b1;
    @(negedge clk);
    src[ch] = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    src = '0; iack = 0; io_wr = 0; io_rd = 0;
    resetq = 0;
    repeat (2) @(negedge clk);
    resetq = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    resetq = 0;
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_tests++; if (ivec !== 4'd0) begin n_fail++; $display("FAIL reset_ivec got=%0d exp=0", ivec); end
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_tests++; if (v !== '0) begin n_fail++; $display("FAIL reset_reg%0d got=%0h exp=0", a, v); end
    end
  endtask

  task automatic test_edge_basic();
    logic [W-1:0] v;
    do_reset();
    wr(2'd0, 18'h01); wr(2'd2, 18'h01);
    pulse_src(0);
    @(negedge clk); @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_early got=%b exp=0", irq); end
    @(negedge clk);
    n_tests++; if (irq !== 1'b1 || ivec !== 4'd1) begin n_fail++; $display("FAIL edge_cycle4 got irq=%b ivec=%0d exp irq=1 ivec=1", irq, ivec); end
    pulse_iack();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_ack1 got=%b exp=0", irq); end
    @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_ack2 got=%b exp=0", irq); end
    rd(2'd1, v);
    n_tests++; if (v !== '0) begin n_fail++; $display("FAIL edge_pending got=%0h exp=0", v); end
  endtask

  task automatic test_priority();
    bit ok;
    do_reset();
    wr(2'd0, 18'hFF); wr(2'd2, 18'hFF);
    src = 8'h24; @(negedge clk); src = '0;
    wait_irq(8, ok);
    n_tests++; if (!ok || ivec !== 4'd3) begin n_fail++; $display("FAIL prio_first got irq=%b ivec=%0d exp irq=1 ivec=3", irq, ivec); end
    pulse_iack();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_gap got=%b exp=0", irq); end
    wait_irq(6, ok);
    n_tests++; if (!ok || ivec !== 4'd6) begin n_fail++; $display("FAIL prio_second got irq=%b ivec=%0d exp irq=1 ivec=6", irq, ivec); end
    pulse_iack();
    repeat (3) @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_quiet got=%b exp=0", irq); end
  endtask

  task automatic test_withdraw();
    logic [W-1:0] v;
    bit ok;
    do_reset();
    wr(2'd0, 18'h10); wr(2'd2, 18'h10);
    pulse_src(4);
    wait_irq(8, ok);
    n_tests++; if (!ok || ivec !== 4'd5) begin n_fail++; $display("FAIL wd_req got irq=%b ivec=%0d exp irq=1 ivec=5", irq, ivec); end
    wr(2'd0, 18'h00);
    @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wd_drop got=%b exp=0", irq); end
    rd(2'd1, v);
    n_tests++; if (v !== 18'h10) begin n_fail++; $display("FAIL wd_pending got=%0h exp=10", v); end
    wr(2'd0, 18'h10);
    @(negedge clk);
    n_tests++; if (irq !== 1'b1 || ivec !== 4'd5) begin n_fail++; $display("FAIL wd_rearm got irq=%b ivec=%0d exp irq=1 ivec=5", irq, ivec); end
    pulse_iack();
  endtask

  task automatic test_level();
    logic [W-1:0] v;
    bit ok;
    do_reset();
    wr(2'd0, 18'h02);
    src[1] = 1'b1;
    wait_irq(8, ok);
    n_tests++; if (!ok || ivec !== 4'd2) begin n_fail++; $display("FAIL lvl_req got irq=%b ivec=%0d exp irq=1 ivec=2", irq, ivec); end
    pulse_iack();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lvl_gap got=%b exp=0", irq); end
    wait_irq(4, ok);
    n_tests++; if (!ok || ivec !== 4'd2) begin n_fail++; $display("FAIL lvl_rereq got irq=%b ivec=%0d exp irq=1 ivec=2", irq, ivec); end
    src[1] = 1'b0;
    for (int i = 0; i < 8 && irq === 1'b1; i++) @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lvl_withdraw got=%b exp=0", irq); end
    rd(2'd1, v);
    n_tests++; if (v !== '0) begin n_fail++; $display("FAIL lvl_pending got=%0h exp=0", v); end
  endtask

  task automatic test_set_wins();
    logic [W-1:0] v;
    do_reset();
    wr(2'd2, 18'h01);
    wr(2'd3, 18'h01);
    rd(2'd1, v);
    n_tests++; if (v !== 18'h01) begin n_fail++; $display("FAIL sw_trig got=%0h exp=1", v); end
    src[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    wr(2'd1, 18'h01);
    rd(2'd1, v);
    n_tests++; if (v !== 18'h01) begin n_fail++; $display("FAIL set_wins got=%0h exp=1", v); end
    src[0] = 1'b0;
    wr(2'd1, 18'h01);
    rd(2'd1, v);
    n_tests++; if (v !== '0) begin n_fail++; $display("FAIL w1c got=%0h exp=0", v); end
  endtask

  task automatic test_reset_mid_req();
    logic [W-1:0] v;
    bit ok;
    do_reset();
    wr(2'd0, 18'h01); wr(2'd2, 18'h01);
    pulse_src(0);
    wait_irq(8, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_req got irq=%b exp=1", irq); end
    resetq = 0;
    #1;
    n_tests++; if (irq !== 1'b0 || ivec !== 4'd0) begin n_fail++; $display("FAIL rst_async got irq=%b ivec=%0d exp 0 0", irq, ivec); end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      n_tests++; if (v !== '0) begin n_fail++; $display("FAIL rst_reg%0d got=%0h exp=0", a, v); end
    end
    @(negedge clk);
    resetq = 1;
    repeat (3) @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_after got=%b exp=0", irq); end
  endtask

  task automatic test_random();
    logic [W-1:0] v, exp_v;
    logic [1:0]   a;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      n_tests++;
      if (irq !== m_busy || (m_busy && ivec !== 4'(VB + m_chan))) begin
        n_fail++;
        $display("FAIL rnd_irq cyc=%0d got irq=%b ivec=%0d exp irq=%b ivec=%0d", cyc, irq, ivec, m_busy, 4'(VB + m_chan));
      end
      a = 2'($urandom_range(0, 3));
      rd(a, v);
      case (a)
        2'd0:    exp_v = W'(m_en);
        2'd1:    exp_v = W'(m_pend);
        2'd2:    exp_v = W'(m_mode);
        default: exp_v = '0;
      endcase
      n_tests++; if (v !== exp_v) begin n_fail++; $display("FAIL rnd_read cyc=%0d addr=%0d got=%0h exp=%0h", cyc, a, v, exp_v); end
      for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) src[k] = ~src[k];
      iack = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      io_wr = ($urandom_range(0, 9) == 0);
      io_addr = 2'($urandom_range(0, 3));
      if (io_addr == 2'd2 && $urandom_range(0, 1) == 0) io_wr = 0;
      din = W'($urandom);
      @(negedge clk);
    end
    io_wr = 0; iack = 0; src = '0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_withdraw();
    test_level();
    test_set_wins();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
